mram_cmd_serializer: RTL and testbench
======================================

# mram_cmd_serializer

Parallel-to-serial command transmitter feeding the MRAM-side serial-to-parallel stage. Accepts one parallel MRAM command (20-bit address, 16-bit data, read/write flag) per valid/ready handshake. Shifts address and data out LSB-first on two serial lines, framed by a `ctrl` strobe. The downstream deserializer samples these lines on the same `clk` rising edge.

## Interface
Parameters:
- `ADDR_W`, 20, address width; also frame length in cycles
- `DATA_W`, 16, data width; must be ≤ `ADDR_W`
- `GAP`, 2, minimum `ctrl`-low cycles between frames; must be ≥ 1

Ports:
- `clk`  input  1  system clock; all logic on rising edge
- `rst`  input  1  asynchronous, active-low reset (0 = reset)
- `cmd_valid`  input  1  command present on `cmd_*`
- `cmd_ready`  output  1  block can accept a command this cycle
- `cmd_addr`  input  `ADDR_W`  command address
- `cmd_data`  input  `DATA_W`  command write data
- `cmd_write`  input  1  1 = write, 0 = read
- `ctrl`  output  1  frame strobe; high for every bit cycle of a frame
- `addr_in`  output  1  serial address bit to downstream
- `data_in`  output  1  serial data bit to downstream
- `rw_out`  output  1  latched `cmd_write`; stable for the whole frame
- `frame_done`  output  1  one-cycle pulse when a frame completes

## Operation
- All outputs are registered.
- FSM states and transitions:
  - IDLE → SHIFT on handshake (`cmd_valid & cmd_ready` at a rising edge).
  - SHIFT → GAP after the last bit, or SHIFT → IDLE when `GAP`=1.
  - GAP → IDLE after `GAP`−1 cycles.
- `cmd_ready` = 1 only in IDLE. It is not combinationally dependent on `cmd_valid`.
- On handshake:
  - `cmd_addr`, `cmd_data` and `cmd_write` are captured into internal shift registers.
  - Changes on `cmd_*` after the accepting edge have no effect on the frame in flight.
- SHIFT:
  - Bit counter runs 0..`ADDR_W`−1.
  - `addr_in` = addr[i]; `data_in` = data[i] for i < `DATA_W`, else 0.
  - `ctrl` = 1; `rw_out` = captured flag.
- Leaving SHIFT:
  - `ctrl`, `addr_in`, `data_in` and `rw_out` go to 0.
  - `frame_done` = 1 for exactly one cycle.
- Bit counter width is ceil(log2(`ADDR_W`)). The counter does not wrap: it clears on the next handshake.
- Reset values (async, `rst`=0): all outputs 0, including `cmd_ready`; FSM in IDLE, counters cleared. `cmd_ready` rises after the first rising edge with `rst`=1.
- Reset mid-frame:
  - The frame is abandoned immediately and `ctrl` drops asynchronously.
  - No `frame_done` pulse is produced.
  - A held `cmd_valid` is re-accepted as a new command after reset release.

## Timing
- Handshake at edge k → after edge k: `ctrl`=1, `addr_in`=addr[0], `data_in`=data[0].
- Bit i is valid after edge k+i, for i = 0..`ADDR_W`−1. Defaults: `ctrl` high for exactly 20 cycles.
- After edge k+`ADDR_W`: `ctrl`=0 and `frame_done`=1 (one cycle).
- `cmd_ready` returns to 1 after edge k+`ADDR_W`+`GAP`−1. The earliest next handshake is at edge k+`ADDR_W`+`GAP`.
- Minimum gap between frames: exactly `GAP` `ctrl`-low cycles. Back-to-back throughput is one command per `ADDR_W`+`GAP` cycles (22 with defaults).
- `cmd_valid` high while `cmd_ready`=0 is held off without loss; the command is accepted on the first edge with `cmd_ready`=1.

## Test plan
- Reset:
  - Stimulus: assert `rst`=0 mid-simulation with `cmd_valid`=1.
  - Required response: all outputs 0 immediately (asynchronous); `cmd_ready`=1 one edge after release.
- Single write:
  - Stimulus: addr 0xABCDE, data 0x1234, `cmd_write`=1.
  - Required response: `addr_in` sequence LSB-first = 0,1,1,1,1,0,1,1,0,0,1,1,1,1,0,1,0,1,0,1; `data_in` = 0x1234 LSB-first, then 0,0,0,0.
  - Required response: `ctrl` high 20 cycles, `rw_out`=1 throughout, `frame_done` one pulse.
  - Required response: a downstream serial_to_parallel instance captures `addr_out`=0xABCDE and `data_out`=0x1234.
- Back-to-back:
  - Stimulus: `cmd_valid` held high with two commands (0x00001/0xFFFF write, then 0x80000/0x0000 read).
  - Required response: second handshake exactly 22 cycles after the first; `ctrl` low for exactly 2 cycles between frames.
  - Required response: `rw_out`=0 in frame 2; `addr_in` is 1 only on bit 19 of frame 2.
- Input isolation:
  - Stimulus: change `cmd_addr`/`cmd_data` every cycle after the accepting edge.
  - Required response: the serial stream still matches the captured values.
- Reset mid-frame:
  - Stimulus: assert `rst`=0 during bit 7.
  - Required response: `ctrl`=0 at once; no `frame_done`.
  - Required response: after release, the held command is sent as a full 20-bit frame from bit 0.
- Extremes:
  - Stimulus: addr 0xFFFFF, data 0xFFFF.
  - Required response: `addr_in`=1 for 20 cycles; `data_in`=1 for bits 0–15 and 0 for bits 16–19.

Source files
------------

// File: rtl/mram_cmd_serializer.sv
// Parallel-to-serial MRAM command transmitter: one command per handshake, shifted
// out LSB-first on addr_in/data_in while ctrl frames the bits.
module mram_cmd_serializer #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_write,
  output logic              ctrl,
  output logic              addr_in,
  output logic              data_in,
  output logic              rw_out,
  output logic              frame_done
);

  localparam int unsigned CNT_W    = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int unsigned GAP_W    = (GAP > 2) ? $clog2(GAP - 1) : 1;
  localparam int unsigned GAP_LAST = (GAP > 1) ? GAP - 2 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
  logic [ADDR_W-1:0] data_sr_q, data_sr_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              ctrl_q, ctrl_d;
  logic              addr_in_q, addr_in_d;
  logic              data_in_q, data_in_d;
  logic              rw_out_q, rw_out_d;
  logic              frame_done_q, frame_done_d;

  // Bit 0 is presented directly at the accepting edge; the shift registers
  // hold the remaining bits. Data is zero-extended so trailing bits read 0.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    addr_sr_d    = addr_sr_q;
    data_sr_d    = data_sr_q;
    cmd_ready_d  = cmd_ready_q;
    ctrl_d       = ctrl_q;
    addr_in_d    = addr_in_q;
    data_in_d    = data_in_q;
    rw_out_d     = rw_out_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_ready_q && cmd_valid) begin
          state_d     = S_SHIFT;
          cmd_ready_d = 1'b0;
          bit_cnt_d   = '0;
          addr_sr_d   = cmd_addr >> 1;
          data_sr_d   = ADDR_W'(cmd_data) >> 1;
          addr_in_d   = cmd_addr[0];
          data_in_d   = cmd_data[0];
          rw_out_d    = cmd_write;
          ctrl_d      = 1'b1;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
          ctrl_d       = 1'b0;
          addr_in_d    = 1'b0;
          data_in_d    = 1'b0;
          rw_out_d     = 1'b0;
          frame_done_d = 1'b1;
          gap_cnt_d    = '0;
          if (GAP == 1) begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          addr_in_d = addr_sr_q[0];
          data_in_d = data_sr_q[0];
          addr_sr_d = addr_sr_q >> 1;
          data_sr_d = data_sr_q >> 1;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b0;
        ctrl_d      = 1'b0;
        addr_in_d   = 1'b0;
        data_in_d   = 1'b0;
        rw_out_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      addr_sr_q    <= '0;
      data_sr_q    <= '0;
      cmd_ready_q  <= 1'b0;
      ctrl_q       <= 1'b0;
      addr_in_q    <= 1'b0;
      data_in_q    <= 1'b0;
      rw_out_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      addr_sr_q    <= addr_sr_d;
      data_sr_q    <= data_sr_d;
      cmd_ready_q  <= cmd_ready_d;
      ctrl_q       <= ctrl_d;
      addr_in_q    <= addr_in_d;
      data_in_q    <= data_in_d;
      rw_out_q     <= rw_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign ctrl       = ctrl_q;
  assign addr_in    = addr_in_q;
  assign data_in    = data_in_q;
  assign rw_out     = rw_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mram_cmd_serializer.sv
// Directed bench for mram_cmd_serializer: table of single frames plus
// back-to-back, input isolation and reset corner sequences.
module tb_mram_cmd_serializer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_write;
  logic        ctrl;
  logic        addr_in;
  logic        data_in;
  logic        rw_out;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mram_cmd_serializer #(.ADDR_W(20), .DATA_W(16), .GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_write  (cmd_write),
    .ctrl       (ctrl),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .rw_out     (rw_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // {ctrl, addr_in, data_in, rw_out, frame_done, cmd_ready}
  function automatic logic [5:0] outs();
    return {ctrl, addr_in, data_in, rw_out, frame_done, cmd_ready};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    logic        wr;
    bit          mutate;
  } vec_t;

  // Drives one command, waits (bounded) for acceptance, then checks every bit
  // cycle and the completion cycle. A downstream deserializer is modelled by
  // capturing the serial lines while ctrl is high.
  task automatic run_frame(input logic [19:0] a, input logic [15:0] d, input logic w,
                           input bit mutate, input bit nv_valid,
                           input logic [19:0] na, input logic [15:0] nd, input logic nw,
                           output int hs);
    int          n;
    logic [19:0] cap_a;
    logic [15:0] cap_d;
    logic        exp_d;
    cap_a = '0;
    cap_d = '0;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_write = w;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("handshake_timeout", 32'(n), 32'(0));
      cmd_valid = 1'b0;
      hs = -1;
      return;
    end
    @(negedge clk);
    hs = cyc;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) begin
        cmd_valid = nv_valid;
        if (nv_valid) begin
          cmd_addr  = na;
          cmd_data  = nd;
          cmd_write = nw;
        end
      end
      if (mutate) begin
        cmd_addr  = 20'($urandom);
        cmd_data  = 16'($urandom);
        cmd_write = ~w;
      end
      exp_d = (i < 16) ? d[i] : 1'b0;
      chk($sformatf("frame_a%05h_bit%0d", a, i), 32'(outs()),
          32'({1'b1, a[i], exp_d, w, 1'b0, 1'b0}));
      cap_a[i] = addr_in;
      if (i < 16) cap_d[i] = data_in;
    end
    @(negedge clk);
    chk($sformatf("frame_a%05h_done", a), 32'(outs()), 32'(6'b000010));
    chk($sformatf("deser_a%05h_addr", a), 32'(cap_a), 32'(a));
    chk($sformatf("deser_a%05h_data", a), 32'(cap_d), 32'(d));
  endtask

  vec_t vecs[4];
  int   hs1, hs2, hs3;

  initial begin
    vecs[0] = '{addr: 20'hABCDE, data: 16'h1234, wr: 1'b1, mutate: 1'b0};
    vecs[1] = '{addr: 20'hFFFFF, data: 16'hFFFF, wr: 1'b1, mutate: 1'b0};
    vecs[2] = '{addr: 20'h5A5A5, data: 16'h0F0F, wr: 1'b0, mutate: 1'b1};
    vecs[3] = '{addr: 20'h00000, data: 16'h0000, wr: 1'b0, mutate: 1'b0};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(outs()), 32'(6'b000000));
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(outs()), 32'(6'b000001));

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].addr, vecs[v].data, vecs[v].wr, vecs[v].mutate,
                1'b0, 20'h0, 16'h0, 1'b0, hs1);
      @(negedge clk);
      chk($sformatf("vec%0d_ready_after_gap", v), 32'(outs()), 32'(6'b000001));
    end

    // Back-to-back with valid held: second command queued right after acceptance.
    run_frame(20'h00001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 20'h80000, 16'h0000, 1'b0, hs1);
    @(negedge clk);
    chk("b2b_gap_cycle", 32'(outs()), 32'(6'b000001));
    run_frame(20'h80000, 16'h0000, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0, 1'b0, hs2);
    chk("b2b_spacing", 32'(hs2 - hs1), 32'(22));
    @(negedge clk);
    chk("b2b_idle", 32'(outs()), 32'(6'b000001));

    // Reset during bit 7 with the command held valid.
    cmd_addr  = 20'h3C3C3;
    cmd_data  = 16'hA5A5;
    cmd_write = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    chk("midframe_bit7", 32'(outs()), 32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0;
    #1;
    chk("midframe_async_clear", 32'(outs()), 32'(6'b000000));
    repeat (2) @(negedge clk);
    chk("midframe_no_done", 32'(outs()), 32'(6'b000000));
    rst = 1'b1;
    @(negedge clk);
    chk("midframe_ready_after_release", 32'(outs()), 32'(6'b000001));
    run_frame(20'h3C3C3, 16'hA5A5, 1'b1, 1'b0, 1'b0, 20'h0, 16'h0, 1'b0, hs3);
    @(negedge clk);
    chk("final_idle", 32'(outs()), 32'(6'b000001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
